// File: rtl/edge_pkg.sv
// Shared definitions for the edge pulse bank.
//
// Holds the per-channel edge-select encodings and the helper that decides
// whether a level toggle matches the selected edge type.
package edge_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    // Width of the per-channel debounce counter.
    localparam int unsigned DB_W = 8;

    // True when a toggle that lands on new_level matches the edge select.
    function automatic logic edge_qualifies(input logic [1:0] mode, input logic new_level);
        logic q;
        q = 1'b0;
        case (edge_mode_e'(mode))
            EDGE_OFF:  q = 1'b0;
            EDGE_RISE: q = new_level;
            EDGE_FALL: q = ~new_level;
            EDGE_BOTH: q = 1'b1;
            default:   q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel of the edge pulse bank.
//
// Synchronises a raw asynchronous input, optionally debounces it, and turns
// selected level toggles into a stretched pulse with retrigger, overrun and a
// sticky "edge seen" flag.
//
// Build option: EDGE_DEBOUNCE_EN
//   defined   - an 8-bit debounce counter must see DB_CNT consecutive
//               mismatching cycles before the level toggles.
//   undefined - the level is the synchroniser output registered once;
//               DB_CNT only takes part in the legality check.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   d        raw asynchronous input
//   mode     edge select (off / rise / fall / both)
//   clr      write-1-to-clear for sticky
//   level    filtered, synchronised level
//   ped      edge pulse, PW cycles wide
//   sticky   latched edge-seen flag
//   overrun  one-cycle flag: qualifying edge while ped was already high
module edge_chan
    import edge_pkg::*;
#(
    parameter int unsigned SYNC   = 2,
    parameter int unsigned DB_CNT = 10,
    parameter int unsigned PW     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       level,
    output logic       ped,
    output logic       sticky,
    output logic       overrun
);

    localparam int unsigned    PCW     = $clog2(PW + 1);
    localparam logic [PCW-1:0] PW_LOAD = PCW'(PW);

    if (SYNC < 2 || DB_CNT < 1 || DB_CNT > 255 || PW < 1 || PW > 255) begin : g_bad_param
        $error("edge_chan: parameter out of range");
    end

    logic [SYNC-1:0] sync_q;
    logic            s;
    logic            level_q;
    logic            level_d;
    logic            toggle;
    logic            qual;
    logic [PCW-1:0]  pcnt_q;
    logic [PCW-1:0]  pcnt_d;
    logic            sticky_q;
    logic            sticky_d;
    logic            overrun_q;
    logic            overrun_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], d};
        end
    end

    assign s = sync_q[SYNC-1];

`ifdef EDGE_DEBOUNCE_EN
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CNT - 1);

    logic [DB_W-1:0] db_q;
    logic [DB_W-1:0] db_d;

    // Count consecutive cycles where the synchronised input disagrees with
    // the accepted level; the count that would reach DB_CNT flips the level.
    always_comb begin
        db_d   = '0;
        toggle = 1'b0;
        if (s != level_q) begin
            if (db_q == DB_LAST) begin
                toggle = 1'b1;
            end else begin
                db_d = db_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_q <= '0;
        end else begin
            db_q <= db_d;
        end
    end
`else
    assign toggle = (s != level_q);
`endif

    assign level_d = level_q ^ toggle;
    assign qual    = toggle & edge_qualifies(mode, level_d);

    // A qualifying edge reloads the full width, so retriggers extend the
    // pulse without a gap; the counter otherwise runs down to zero and stops.
    always_comb begin
        pcnt_d    = pcnt_q;
        overrun_d = 1'b0;
        if (qual) begin
            pcnt_d    = PW_LOAD;
            overrun_d = (pcnt_q != '0);
        end else if (pcnt_q != '0) begin
            pcnt_d = pcnt_q - PCW'(1);
        end
    end

    // Set wins over a simultaneous clear.
    assign sticky_d = qual | (sticky_q & ~clr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q   <= 1'b0;
            pcnt_q    <= '0;
            sticky_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            pcnt_q    <= pcnt_d;
            sticky_q  <= sticky_d;
            overrun_q <= overrun_d;
        end
    end

    assign level   = level_q;
    assign ped     = (pcnt_q != '0);
    assign sticky  = sticky_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/edge_pulse_bank.sv
// Multi-channel edge-to-pulse generator.
//
// CH independent channels, each synchronised, optionally debounced and
// converted into a PW-cycle pulse on the edges selected by its mode field.
//
// Build option: EDGE_DEBOUNCE_EN enables the per-channel debounce counter
// (see edge_chan); when undefined the level follows the synchroniser with one
// extra register stage.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   d        [CH]    raw asynchronous inputs
//   mode     [2*CH]  edge select, mode[2i+1:2i] for channel i
//   clr      [CH]    write-1-to-clear for sticky
//   level    [CH]    filtered, synchronised levels
//   ped      [CH]    edge pulses
//   sticky   [CH]    latched edge-seen flags
//   overrun  [CH]    one-cycle retrigger flags
module edge_pulse_bank
    import edge_pkg::*;
#(
    parameter int unsigned CH     = 4,
    parameter int unsigned SYNC   = 2,
    parameter int unsigned DB_CNT = 10,
    parameter int unsigned PW     = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CH-1:0]   d,
    input  logic [2*CH-1:0] mode,
    input  logic [CH-1:0]   clr,
    output logic [CH-1:0]   level,
    output logic [CH-1:0]   ped,
    output logic [CH-1:0]   sticky,
    output logic [CH-1:0]   overrun
);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        edge_chan #(
            .SYNC   (SYNC),
            .DB_CNT (DB_CNT),
            .PW     (PW)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .d       (d[i]),
            .mode    (mode[2*i +: 2]),
            .clr     (clr[i]),
            .level   (level[i]),
            .ped     (ped[i]),
            .sticky  (sticky[i]),
            .overrun (overrun[i])
        );
    end

endmodule

// File: doc/edge_pulse_bank.md
# edge_pulse_bank

Parametrised multi-channel edge-to-pulse generator. It is the successor to the single-bit rising-edge pulse maker. Each of `CH` asynchronous inputs passes through a synchroniser and an optional debounce filter. Selected edges are then converted into a pulse of programmable width, with retrigger, overrun flag and a sticky event bit per channel. It sits between the board-level inputs (buttons, external strobes) and the TX/RX control logic that consumes single-cycle or stretched strobes.

## Interface
- `CH`, 4: number of independent channels.
- `SYNC`, 2: synchroniser depth in flops. Legal range ≥ 2.
- `DB_CNT`, 10: consecutive stable cycles needed to accept a new level. Legal range 1..255.
- `PW`, 1: output pulse width in cycles. Legal range 1..255.
- `clk`  in  1  single system clock; all state is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `d`  in  CH  raw asynchronous inputs.
- `mode`  in  2*CH  per-channel edge select, `mode[2i+1:2i]` for channel i: 00 off, 01 rise, 10 fall, 11 both.
- `clr`  in  CH  write-1-to-clear for `sticky`.
- `level`  out  CH  filtered, synchronised level.
- `ped`  out  CH  edge pulse, held for `PW` cycles.
- `sticky`  out  CH  latched "edge seen" flag.
- `overrun`  out  CH  1-cycle flag: a qualifying edge arrived while `ped` was already high.

## Operation
- **Reset.** While `reset`=0, every flop is cleared: synchroniser, debounce counter, `level`, pulse counter, `ped`, `sticky`, `overrun` all = 0. This is asynchronous and independent of `clk`.
- **Synchroniser.** `d[i]` passes through a `SYNC`-flop chain. The chain output is `s[i]`.
- **Debounce counter.** Each channel has an 8-bit counter.
  - When `s` ≠ `level`, the counter increments.
  - When `s` = `level`, the counter clears to 0.
  - On the edge where the count would reach `DB_CNT`, `level` toggles and the counter clears.
  - A glitch shorter than `DB_CNT` cycles never changes `level`.
- **Qualifying edge.** A `level` toggle is qualifying when it matches `mode`: 0→1 for rise, 1→0 for fall, either for both. Mode 00 never qualifies, but `level` still tracks the input.
- **Pulse.** A qualifying edge loads the pulse down-counter with `PW`. `ped` = (counter ≠ 0). `ped` is registered and rises on the same clock edge as the `level` toggle.
- **Retrigger.** A qualifying edge while the counter is ≠ 0 reloads it to `PW`, so the pulse is extended with no gap. `overrun` is asserted for exactly that one cycle.
- **Sticky.** `sticky` is set on a qualifying edge and cleared by `clr`. If set and `clr` occur in the same cycle, set wins.
- **Mode changes.** A change of `mode` takes effect for level toggles on the next clock edge. A pulse already in progress completes.
- **Reset release with inputs high.** Because `level` resets to 0, an input that is already high at release produces a rising edge once it has passed the synchroniser and filter. This is required behaviour.

## Timing
- Latency from a stable change on `d` to the `level`/`ped` change:
  - with debounce: `SYNC`+`DB_CNT` clock edges;
  - without debounce: `SYNC`+1 clock edges.
- `ped` high time is exactly `PW` cycles per isolated edge. With retrigger, it stays high until `PW` cycles after the last qualifying edge.
- `overrun` and `sticky` change on the same clock edge as `ped` rises or reloads.
- The counter width for `PW` is $clog2(`PW`+1). The pulse counter never wraps.
- If reset is asserted mid-pulse, `ped` drops immediately. No pulse resumes after release unless a new edge qualifies.

## Configuration
- `EDGE_DEBOUNCE_EN` defined: the debounce counter is compiled in and behaves as above.
- `EDGE_DEBOUNCE_EN` undefined: there is no counter. `level` is `s` registered once, and `DB_CNT` is ignored.

## Structure
- Shared package `edge_pkg` holds the mode encodings: `EDGE_OFF`=2'b00, `EDGE_RISE`=2'b01, `EDGE_FALL`=2'b10, `EDGE_BOTH`=2'b11.
- The top level is a generate loop over `CH` instances of the sub-module `edge_chan`. `edge_chan` contains the synchroniser, debounce counter, pulse counter and sticky logic for one channel.

## Test plan
All scenarios use `CH`=4, `SYNC`=2, `DB_CNT`=10, `PW`=3, with `EDGE_DEBOUNCE_EN` defined unless stated.
1. Hold `reset`=0 with `d`=4'hF → all outputs 0. Release with `mode` all 01 → `level`=F and `ped`=F exactly 12 edges after release, `ped` high for 3 cycles, `sticky`=F.
2. Drive `d[0]` high for 9 cycles, then low → `level[0]`, `ped[0]` and `sticky[0]` all stay 0. Repeat with 10 cycles → `level[0]` rises at edge 12.
3. Set `mode[3:2]`=10 and toggle `d[1]` 0→1→0 with 20-cycle spacing → `ped[1]` high for 3 cycles only after the falling transition.
4. Use `PW`=30, mode 11, and toggle `d[2]` every 12 cycles → `ped[2]` stays continuously high, `overrun[2]` pulses once per toggle after the first, and `ped[2]` falls 30 cycles after the last edge.
5. Assert `clr[3]` in the same cycle as a qualifying edge → `sticky[3]`=1. Assert `clr[3]` on the next cycle → `sticky[3]`=0.
6. Set mode 00 on all channels and toggle `d` → `level` tracks the inputs while `ped`, `sticky` and `overrun` stay 0. Repeat with `EDGE_DEBOUNCE_EN` undefined → latency is 3 edges.
